pattern_sequencer: RTL and testbench

- Upstream feeder for the falling-note lane block. It supplies the 4-bit lane pattern on that block's command_in.
- Uses a Galois LFSR with difficulty-limited note count, so every pattern is nonzero and within the level's note budget.
- Pre-generates the next pattern. The value is stable on command_out when the lane block pulses trocar, and is replaced after the consumer has latched it.
- Counts delivered patterns and flags end of song.

---
 rtl/pattern_sequencer.sv | 146 ++++++++++++++
 tb/tb_pattern_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: LFSR-driven lane-pattern feeder with note budget, hold window and song counter.
// Define REPEAT_FILTER_EN to forbid two identical consecutive patterns.
module pattern_sequencer #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          SONG_LEN    = 64,
  parameter int          HOLD_CYCLES = 2,
  parameter int          MAX_TRIES   = 15
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] level,
  input  logic       trocar,
  output logic [3:0] command_out,
  output logic       pattern_valid,
  output logic [7:0] pattern_index,
  output logic       busy,
  output logic       song_done
);
`ifdef REPEAT_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif
  localparam logic [15:0] SEED_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int HOLD = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int HW = $clog2(HOLD + 1);
  localparam int TW = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
  localparam logic [7:0] LAST = 8'(SONG_LEN);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, GEN, DONE} state_t;

  state_t        state, state_n;
  logic [15:0]   lfsr, lfsr_n;
  logic [3:0]    prev, prev_n, cmd_n, cand, fb_raw, fb, pick;
  logic [7:0]    idx_n;
  logic [TW-1:0] tries, tries_n;
  logic [HW-1:0] hold, hold_n;
  logic [2:0]    pc;
  logic          valid_n, pending, pending_n, finish, finish_n, start_q, trocar_q;
  logic          start_rise, trocar_rise, searching, ok, last_try, found, take;

  assign start_rise  = start & ~start_q;
  assign trocar_rise = trocar & ~trocar_q;
  assign searching   = state == PRIME || state == GEN;
  assign cand        = lfsr[3:0];
  assign pc          = 3'(cand[0]) + 3'(cand[1]) + 3'(cand[2]) + 3'(cand[3]);
  assign ok          = cand != 4'h0 && pc <= {1'b0, level} + 3'd1 && !(FILTER && cand == prev);
  assign fb_raw      = 4'b0001 << lfsr[1:0];
  assign fb          = (FILTER && fb_raw == prev) ? {fb_raw[2:0], fb_raw[3]} : fb_raw;
  assign last_try    = tries == TW'(MAX_TRIES);
  assign found       = searching && (last_try || ok);
  assign pick        = last_try ? fb : cand;
  // a request edge is only counted/queued while the queue slot is free and the song is not full
  assign take        = trocar_rise && !pending && pattern_index != LAST;
  assign busy        = searching;
  assign song_done   = state == DONE;

  always_comb begin
    state_n   = state;
    lfsr_n    = searching ? ({1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000)) : lfsr;
    cmd_n     = command_out;
    prev_n    = prev;
    valid_n   = pattern_valid;
    idx_n     = pattern_index;
    pending_n = pending;
    finish_n  = finish;
    hold_n    = hold;
    tries_n   = found ? '0 : searching ? tries + 1'b1 : tries;
    case (state)
      IDLE: state_n = start_rise ? PRIME : IDLE;
      PRIME, GEN: begin
        if (state == GEN && take) begin
          pending_n = 1'b1;
          idx_n     = pattern_index + 8'd1;
        end
        if (found) begin
          cmd_n   = pick;
          prev_n  = pick;
          valid_n = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (hold != '0) begin
          hold_n = hold - 1'b1;
          if (take) begin
            pending_n = 1'b1;
            idx_n     = pattern_index + 8'd1;
          end
          if (hold == HW'(1)) begin
            state_n = finish ? DONE : GEN;
            cmd_n   = finish ? 4'h0 : command_out;
            valid_n = finish ? 1'b0 : pattern_valid;
          end
        end else if (pending) begin
          hold_n    = HW'(HOLD);
          pending_n = 1'b0;
          finish_n  = pattern_index == LAST;
        end else if (take) begin
          hold_n   = HW'(HOLD);
          idx_n    = pattern_index + 8'd1;
          finish_n = pattern_index + 8'd1 == LAST;
        end
      end
      DONE: begin
        if (start_rise) begin
          state_n = PRIME;
          idx_n   = 8'd0;
          prev_n  = 4'h0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      lfsr          <= SEED_INIT;
      command_out   <= 4'h0;
      prev          <= 4'h0;
      pattern_valid <= 1'b0;
      pattern_index <= 8'd0;
      pending       <= 1'b0;
      finish        <= 1'b0;
      tries         <= '0;
      hold          <= '0;
      start_q       <= 1'b0;
      trocar_q      <= 1'b0;
    end else begin
      state         <= state_n;
      lfsr          <= lfsr_n;
      command_out   <= cmd_n;
      prev          <= prev_n;
      pattern_valid <= valid_n;
      pattern_index <= idx_n;
      pending       <= pending_n;
      finish        <= finish_n;
      tries         <= tries_n;
      hold          <= hold_n;
      start_q       <= start;
      trocar_q      <= trocar;
    end
  end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed and randomized checks against a search-level reference model.
// Build with REPEAT_FILTER_EN defined to also check the no-repeat property.
`timescale 1ns/1ps
module tb_pattern_sequencer;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int SL = 4;
  localparam int MAXT = 15;
`ifdef REPEAT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, trocar;
  logic [1:0] level;
  logic [3:0] command_out;
  logic       pattern_valid, busy, song_done;
  logic [7:0] pattern_index;

  int checks = 0, errors = 0, cyc = 0;
  logic [15:0] m_lfsr;
  logic [3:0]  m_prev;
  int          m_idx;

  pattern_sequencer #(.SEED(SEED), .SONG_LEN(SL), .HOLD_CYCLES(2), .MAX_TRIES(MAXT)) dut (
    .CLOCK_25(clk), .reset(reset), .start(start), .level(level), .trocar(trocar),
    .command_out(command_out), .pattern_valid(pattern_valid), .pattern_index(pattern_index),
    .busy(busy), .song_done(song_done)
  );

  always #20 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // One search: walk the LFSR until a candidate fits the rules, or take the one-hot fallback.
  function automatic void search(input logic [1:0] lv, output logic [3:0] pat, output int lat);
    logic [3:0] c;
    pat = 4'h0;
    lat = 0;
    for (int t = 0; t <= MAXT && pat == 4'h0; t++) begin
      c = m_lfsr[3:0];
      if (t == MAXT) begin
        pat = 4'b0001 << m_lfsr[1:0];
        if (FILT && pat == m_prev) pat = {pat[2:0], pat[3]};
      end else if (c != 4'h0 && $countones(c) <= int'(lv) + 1 && !(FILT && c == m_prev)) begin
        pat = c;
      end
      m_lfsr = step(m_lfsr);
      lat = t + 1;
    end
    m_prev = pat;
  endfunction

  task automatic wait_search(input logic [1:0] lv, output int n);
    logic [3:0] p;
    int lat;
    search(lv, p, lat);
    n = 0;
    while (busy && n < 40) begin
      tick;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("pattern", 32'(command_out), 32'(p));
    chk("valid", 32'(pattern_valid), 1);
    chk("budget", 32'(command_out != 4'h0 && $countones(command_out) <= int'(lv) + 1), 1);
  endtask

  task automatic do_start(input logic [1:0] lv, output int n);
    level = lv;
    start = 1'b1;
    tick;
    start = 1'b0;
    m_idx = 0;
    m_prev = 4'h0;
    chk("prime_busy", 32'(busy), 1);
    chk("prime_valid", 32'(pattern_valid), 0);
    wait_search(lv, n);
  endtask

  task automatic do_req(input logic [1:0] lv);
    logic [3:0] old;
    int n;
    old = command_out;
    level = lv;
    trocar = 1'b1;
    tick;
    trocar = 1'b0;
    m_idx++;
    chk("req_index", 32'(pattern_index), 32'(m_idx));
    chk("hold0_cmd", 32'(command_out), 32'(old));
    tick;
    chk("hold1_cmd", 32'(command_out), 32'(old));
    chk("hold1_busy", 32'(busy), 0);
    tick;
    if (m_idx == SL) begin
      chk("done_flag", 32'(song_done), 1);
      chk("done_cmd", 32'(command_out), 0);
      chk("done_valid", 32'(pattern_valid), 0);
      chk("done_busy", 32'(busy), 0);
    end else begin
      chk("gen_busy", 32'(busy), 1);
      chk("gen_cmd", 32'(command_out), 32'(old));
      wait_search(lv, n);
`ifdef REPEAT_FILTER_EN
      chk("no_repeat", 32'(command_out != old), 1);
`endif
    end
  endtask

  initial begin
    logic [3:0] old, p1;
    int n, lat1, t_gen, gap;
    reset = 1'b1;
    start = 1'b0;
    trocar = 1'b0;
    level = 2'd0;
    m_lfsr = SEED;
    m_prev = 4'h0;
    m_idx = 0;
    repeat (3) tick;
    reset = 1'b0;
    tick;
    chk("rst_cmd", 32'(command_out), 0);
    chk("rst_valid", 32'(pattern_valid), 0);
    chk("rst_index", 32'(pattern_index), 0);
    chk("rst_done", 32'(song_done), 0);
    chk("rst_busy", 32'(busy), 0);

    do_start(2'd0, n);
    chk("prime_within16", 32'(n <= 16), 1);
    chk("level0_onehot", 32'($countones(command_out)), 1);

    do_req(2'd3);

    // second edge lands in the hold, third while the slot is still occupied
    old = command_out;
    level = 2'd2;
    trocar = 1'b1;
    tick;
    trocar = 1'b0;
    tick;
    trocar = 1'b1;
    tick;
    trocar = 1'b0;
    m_idx += 2;
    t_gen = cyc;
    chk("pend_index", 32'(pattern_index), 32'(m_idx));
    chk("pend_busy", 32'(busy), 1);
    chk("pend_cmd_hold", 32'(command_out), 32'(old));
    search(2'd2, p1, lat1);
    tick;
    trocar = 1'b1;
    tick;
    trocar = 1'b0;
    chk("pend_drop_index", 32'(pattern_index), 32'(m_idx));
    while (busy && cyc - t_gen < 40) tick;
    chk("pend_first_pat", 32'(command_out), 32'(p1));
    while (!busy && cyc - t_gen < 60) tick;
    chk("pend_service_time", 32'(cyc - t_gen), 32'(lat1 + 3));
    chk("pend_cmd_kept", 32'(command_out), 32'(p1));
    wait_search(2'd2, n);
    chk("pend_final_index", 32'(pattern_index), 32'(m_idx));

    do_req(2'd1);
    trocar = 1'b1;
    tick;
    trocar = 1'b0;
    tick;
    chk("extra_index", 32'(pattern_index), SL);
    chk("extra_done", 32'(song_done), 1);
    chk("extra_cmd", 32'(command_out), 0);

    do_start(2'd1, n);
    level = 2'd2;
    trocar = 1'b1;
    tick;
    trocar = 1'b0;
    tick;
    tick;
    chk("midgen_busy", 32'(busy), 1);
    #5 reset = 1'b1;
    #1;
    chk("abort_cmd", 32'(command_out), 0);
    chk("abort_valid", 32'(pattern_valid), 0);
    chk("abort_index", 32'(pattern_index), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(song_done), 0);
    repeat (3) tick;
    reset = 1'b0;
    m_lfsr = SEED;
    m_prev = 4'h0;
    m_idx = 0;

    for (int s = 0; s < 50; s++) begin
      do_start(2'($urandom_range(0, 3)), n);
      for (int r = 0; r < SL; r++) begin
        gap = int'($urandom_range(0, 3));
        repeat (gap) tick;
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1;
          tick;
          start = 1'b0;
          tick;
          chk("start_ignored", 32'(busy), 0);
        end
        do_req(2'($urandom_range(0, 3)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
